// File: rtl/sysled_pwm_pio.sv
`default_nettype none
// ============================================================================
// Module   : sysled_pwm_pio
// Purpose  : Avalon-MM status-LED/indicator output register. Each of WIDTH
//            channels is gated by its DATA bit, can optionally be blinked by
//            a programmable prescaler (BLINK_MASK/PERIOD), and all channels
//            share one PWM brightness duty (DUTY).
// Ports    : clk        - system clock
//            reset      - asynchronous active-high reset
//            address    - register select (0 DATA, 1 BLINK_MASK, 2 PERIOD,
//                         3 DUTY)
//            chipselect - slave select, qualifies writes only
//            write_n    - active-low write strobe
//            writedata  - write data, bits above the register width ignored
//            readdata   - selected register, zero-extended, combinational
//            out_port   - registered LED/indicator outputs
// Revision : 1.0 - initial release
// ============================================================================
module sysled_pwm_pio #(
  parameter int unsigned         WIDTH       = 4,
  parameter int unsigned         PERIOD_BITS = 24,
  parameter int unsigned         PWM_BITS    = 8,
  parameter logic [WIDTH-1:0]    INIT_DATA   = '0,
  parameter logic [PWM_BITS-1:0] INIT_DUTY   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0]             ADDR_DATA   = 2'd0;
  localparam logic [1:0]             ADDR_MASK   = 2'd1;
  localparam logic [1:0]             ADDR_PERIOD = 2'd2;
  localparam logic [1:0]             ADDR_DUTY   = 2'd3;
  localparam logic [PERIOD_BITS-1:0] PRESC_ONE   = PERIOD_BITS'(1);
  localparam logic [PWM_BITS-1:0]    PWM_ONE     = PWM_BITS'(1);

  logic                   wr_en;
  logic [PERIOD_BITS-1:0] wr_period;

  logic [WIDTH-1:0]       data_q,    data_d;
  logic [WIDTH-1:0]       mask_q,    mask_d;
  logic [PERIOD_BITS-1:0] period_q,  period_d;
  logic [PWM_BITS-1:0]    duty_q,    duty_d;
  logic [PERIOD_BITS-1:0] presc_q,   presc_d;
  logic                   phase_q,   phase_d;
  logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0]       out_q,     out_d;
  logic                   pwm_on;

  // Upper writedata bits have no destination; folding them into a named sink
  // keeps the "ignored on purpose" intent visible.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_period = writedata[PERIOD_BITS-1:0];

  // --------------------------------------------------------------------------
  // Register file writes
  // --------------------------------------------------------------------------
  always_comb begin : reg_write
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = writedata[WIDTH-1:0];
        ADDR_MASK:   mask_d   = writedata[WIDTH-1:0];
        ADDR_PERIOD: period_d = wr_period;
        ADDR_DUTY:   duty_d   = writedata[PWM_BITS-1:0];
        default:     data_d   = data_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Blink prescaler. A PERIOD write takes priority over expiry so every
  // reprogram starts from a known phase (on) with a full half-period ahead.
  // --------------------------------------------------------------------------
  always_comb begin : blink
    presc_d = presc_q;
    phase_d = phase_q;
    if (wr_en && (address == ADDR_PERIOD)) begin
      presc_d = (wr_period == '0) ? '0 : (wr_period - PRESC_ONE);
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == '0) begin
      presc_d = period_q - PRESC_ONE;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q - PRESC_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // PWM: all-ones duty is special-cased so full brightness has no dark slot.
  // --------------------------------------------------------------------------
  assign pwm_cnt_d = pwm_cnt_q + PWM_ONE;
  assign pwm_on    = (duty_q == '1) || (pwm_cnt_q < duty_q);

  assign out_d = data_q & (~mask_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= INIT_DATA;
      mask_q    <= '0;
      period_q  <= '0;
      duty_q    <= INIT_DUTY;
      presc_q   <= '0;
      phase_q   <= 1'b1;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      data_q    <= data_d;
      mask_q    <= mask_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign out_port = out_q;

  // --------------------------------------------------------------------------
  // Read mux: combinational, no side effects, independent of chipselect.
  // --------------------------------------------------------------------------
  always_comb begin : read_mux
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]       = data_q;
      ADDR_MASK:   readdata[WIDTH-1:0]       = mask_q;
      ADDR_PERIOD: readdata[PERIOD_BITS-1:0] = period_q;
      ADDR_DUTY:   readdata[PWM_BITS-1:0]    = duty_q;
      default:     readdata                  = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sysled_pwm_pio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sysled_pwm_pio
// Purpose  : Self-checking bench for sysled_pwm_pio. A behavioural model
//            derives the blink phase and PWM state from elapsed cycle counts.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysled_pwm_pio;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int n_pass  = 0;
  int n_total = 0;

  sysled_pwm_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: registers plus cycle counters. Blink phase is on during
  // half-periods 0, 2, 4, ... counted from the cycle after the last PERIOD
  // write; the PWM counter is simply the cycle count modulo 256.
  // --------------------------------------------------------------------------
  logic [3:0]  m_data, m_mask, exp_out;
  logic [23:0] m_period;
  logic [7:0]  m_duty;
  longint      m_cyc, m_pwr;

  function automatic logic [3:0] model_out(input logic [3:0] d, input logic [3:0] m,
                                           input logic [23:0] p, input logic [7:0] du,
                                           input longint cyc, input longint pwr);
    bit     ph;
    bit     on;
    longint cnt;
    if (p == 24'd0) ph = 1'b1;
    else            ph = (((cyc - pwr) / longint'(p)) % 2) == 0;
    cnt = cyc % 256;
    on  = (du == 8'hFF) || (cnt < longint'(du));
    return d & (~m | {4{ph}}) & {4{on}};
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a, input logic [3:0] d,
                                             input logic [3:0] m, input logic [23:0] p,
                                             input logic [7:0] du);
    case (a)
      2'd0:    return {28'd0, d};
      2'd1:    return {28'd0, m};
      2'd2:    return {8'd0, p};
      default: return {24'd0, du};
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data   <= 4'h0;
      m_mask   <= 4'h0;
      m_period <= 24'd0;
      m_duty   <= 8'hFF;
      m_cyc    <= 0;
      m_pwr    <= 0;
      exp_out  <= 4'h0;
    end else begin
      exp_out <= model_out(m_data, m_mask, m_period, m_duty, m_cyc, m_pwr);
      m_cyc   <= m_cyc + 1;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data <= writedata[3:0];
          2'd1: m_mask <= writedata[3:0];
          2'd2: begin
            m_period <= writedata[23:0];
            m_pwr    <= m_cyc + 1;
          end
          default: m_duty <= writedata[7:0];
        endcase
      end
    end
  end

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_port !== 4'h0) $display("FAIL reset_out_held: got %h expected %h", out_port, 4'h0);
    else n_pass++;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      exp_rd = (a == 3) ? 32'h0000_00FF : 32'h0;
      n_total++;
      if (readdata !== exp_rd) $display("FAIL reset_read addr%0d: got %h expected %h", a, readdata, exp_rd);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (out_port !== 4'h0) $display("FAIL reset_idle_out: got %h expected %h", out_port, 4'h0);
    else n_pass++;
  endtask

  task automatic test_data_write();
    bus_write(2'd0, 32'h0000_000A);
    n_total++;
    if (out_port !== 4'h0) $display("FAIL data_latency_early: got %h expected %h", out_port, 4'h0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_port !== 4'hA) $display("FAIL data_out: got %h expected %h", out_port, 4'hA);
    else n_pass++;
    address = 2'd0;
    #1;
    n_total++;
    if (readdata !== 32'h0000_000A) $display("FAIL data_read: got %h expected %h", readdata, 32'hA);
    else n_pass++;
    bus_write(2'd0, 32'hFFFF_FFF5);
    address = 2'd0;
    #1;
    n_total++;
    if (readdata !== 32'h0000_0005) $display("FAIL data_read_trunc: got %h expected %h", readdata, 32'h5);
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'hF);
    bus_write(2'd2, 32'd3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = (((i / 3) % 2) == 0) ? 4'hF : 4'hE;
      n_total++;
      if (out_port !== exp) $display("FAIL blink_p3 cyc%0d: got %h expected %h", i, out_port, exp);
      else n_pass++;
      n_total++;
      if (out_port !== exp_out) $display("FAIL blink_model cyc%0d: got %h expected %h", i, out_port, exp_out);
      else n_pass++;
    end
    bus_write(2'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (out_port !== 4'hF) $display("FAIL blink_p0 cyc%0d: got %h expected %h", i, out_port, 4'hF);
      else n_pass++;
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duties [4];
    int         highs;
    int         model_err;
    int         exp_high;
    duties[0] = 8'h40;
    duties[1] = 8'h00;
    duties[2] = 8'hFF;
    duties[3] = 8'($urandom_range(1, 254));
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h1);
    for (int k = 0; k < 4; k++) begin
      bus_write(2'd3, {24'hABCDEF, duties[k]});
      repeat (2) @(negedge clk);
      highs     = 0;
      model_err = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (out_port[0] === 1'b1) highs++;
        if (out_port !== exp_out) model_err++;
      end
      exp_high = (duties[k] == 8'hFF) ? 256 : int'(duties[k]);
      n_total++;
      if (highs !== exp_high)
        $display("FAIL pwm_high_count duty=%h: got %0d expected %0d", duties[k], highs, exp_high);
      else n_pass++;
      n_total++;
      if (model_err !== 0)
        $display("FAIL pwm_model duty=%h: got %0d mismatching cycles expected 0", duties[k], model_err);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [3:0] exp;
    bus_write(2'd3, 32'hFF);
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'hF);
    bus_write(2'd2, 32'd3);
    repeat (2) @(negedge clk);
    // This write lands on the edge where the 3-clock half-period expires.
    bus_write(2'd2, 32'd4);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = (((i / 4) % 2) == 0) ? 4'hF : 4'hE;
      n_total++;
      if (out_port !== exp) $display("FAIL collision cyc%0d: got %h expected %h", i, out_port, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [1:0]  a;
    int          err_out;
    int          err_rd;
    err_out = 0;
    err_rd  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      if (out_port !== exp_out) begin
        err_out++;
        if (err_out <= 5) $display("FAIL random_out cyc%0d: got %h expected %h", i, out_port, exp_out);
      end
      address = 2'($urandom_range(0, 3));
      #1;
      exp_rd = model_read(address, m_data, m_mask, m_period, m_duty);
      if (readdata !== exp_rd) begin
        err_rd++;
        if (err_rd <= 5) $display("FAIL random_read addr%0d: got %h expected %h", address, readdata, exp_rd);
      end
      if ($urandom_range(0, 3) == 0) begin
        a  = 2'($urandom_range(0, 3));
        wd = $urandom;
        if (a == 2'd2) wd = {wd[31:24], 21'd0, wd[2:0]};
        if (a == 2'd3 && $urandom_range(0, 3) == 0) wd[7:0] = 8'hFF;
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    n_total++;
    if (err_out !== 0) $display("FAIL random_out_total: got %0d mismatches expected 0", err_out);
    else n_pass++;
    n_total++;
    if (err_rd !== 0) $display("FAIL random_read_total: got %0d mismatches expected 0", err_rd);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit          seen;
    logic [31:0] exp_rd;
    bus_write(2'd3, 32'hFF);
    bus_write(2'd1, 32'hF);
    bus_write(2'd0, 32'hF);
    bus_write(2'd2, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_port === 4'hF) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL async_setup: got %h expected %h", out_port, 4'hF);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (out_port !== 4'h0) $display("FAIL async_reset_out: got %h expected %h", out_port, 4'h0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      exp_rd = (a == 3) ? 32'h0000_00FF : 32'h0;
      n_total++;
      if (readdata !== exp_rd) $display("FAIL async_reset_read addr%0d: got %h expected %h", a, readdata, exp_rd);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (out_port !== 4'h0) $display("FAIL async_reset_idle: got %h expected %h", out_port, 4'h0);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_data_write();
    test_blink();
    test_pwm();
    test_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
